trigger_ctrl_mc: RTL

Multi-channel, parametrised trigger controller for the stopwatch datapath. Each channel synchronises and debounces a raw push-button trigger, detects clean rising edges, and runs a start/stop/lap state machine that drives the channel's counter controls: `count_init`, `count_enb` and `latch_count`. It replaces the single-channel trigger detector and adds metastability hardening, debounce, lap mode, long-press stop and per-channel independence.

---
 rtl/trigger_ctrl_mc_pkg.sv | 6 +
 rtl/trigger_ctrl_mc_if.sv | 10 +
 rtl/trigger_ctrl_mc_filter.sv | 42 ++++
 rtl/trigger_ctrl_mc.sv | 77 +++++++
 4 files changed

// File: rtl/trigger_ctrl_mc_pkg.sv
// stopwatch_pkg: shared FSM state and mode encodings for the stopwatch trigger controller
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, INIT, RUN, STOPPED} state_e;
  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_LAP    = 1'b1;
endpackage

// File: rtl/trigger_ctrl_mc_if.sv
// trigger_ctrl_mc_if: per-channel trigger inputs and counter-control outputs
interface trigger_ctrl_mc_if #(parameter int N_CH = 1);
  logic [N_CH-1:0] trigger_in;
  logic [N_CH-1:0] mode_lap;
  logic [N_CH-1:0] latch_count;
  logic [N_CH-1:0] count_enb;
  logic [N_CH-1:0] count_init;
  modport master (output trigger_in, mode_lap, input latch_count, count_enb, count_init);
  modport slave (input trigger_in, mode_lap, output latch_count, count_enb, count_init);
endinterface

// File: rtl/trigger_ctrl_mc_filter.sv
// trigger_filter: synchroniser, debounce and rising-edge detect for one raw trigger
module trigger_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic trig_raw,
  output logic level,
  output logic trig_edge
);
  localparam int DW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, edge_q, edge_d;
  logic differ, at_limit;
  // Count cycles of disagreement; flip the filtered level once the count has reached the limit
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trig_raw};
    differ = sync_q[SYNC_STAGES-1] ^ filt_q;
    at_limit = cnt_q == DW'(DEBOUNCE_CYCLES);
    cnt_d = (differ && !at_limit) ? cnt_q + 1'b1 : '0;
    filt_d = (differ && at_limit) ? ~filt_q : filt_q;
    edge_d = filt_d & ~filt_q;
  end
  // Synchroniser, debounce and edge registers
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      filt_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      filt_q <= filt_d;
      edge_q <= edge_d;
    end
  end
  assign level = filt_q;
  assign trig_edge = edge_q;
endmodule

// File: rtl/trigger_ctrl_mc.sv
// trigger_ctrl_mc: independent start/stop/lap stopwatch controllers, one per trigger channel
module trigger_ctrl_mc
  import stopwatch_pkg::*;
#(
  parameter int N_CH            = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input logic sys_clk,
  input logic reset_n,
  trigger_ctrl_mc_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  genvar c;
  for (c = 0; c < N_CH; c++) begin : g_ch
    logic level, trig_edge, hold_full, long_press;
    state_e state_q, state_d;
    logic mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic latch_q, latch_d, enb_q, enb_d, init_q, init_d;
    trigger_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .sys_clk(sys_clk),
      .reset_n(reset_n),
      .trig_raw(bus.trigger_in[c]),
      .level(level),
      .trig_edge(trig_edge)
    );
    assign hold_full = hold_q == HW'(HOLD_CYCLES);
    assign long_press = mode_q == MODE_LAP && hold_full;
    // State, mode, hold counter and registered outputs
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        mode_q <= MODE_TOGGLE;
        hold_q <= '0;
        latch_q <= 1'b0;
        enb_q <= 1'b0;
        init_q <= 1'b0;
      end else begin
        state_q <= state_d;
        mode_q <= mode_d;
        hold_q <= hold_d;
        latch_q <= latch_d;
        enb_q <= enb_d;
        init_q <= init_d;
      end
    end
    // Next state: start/restart on an edge, stop on a toggle edge or a lap-mode long press
    always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      hold_d = (state_q == RUN && level) ? (hold_full ? hold_q : hold_q + 1'b1) : '0;
      case (state_q)
        IDLE, STOPPED: if (trig_edge) begin
          state_d = INIT;
          mode_d = bus.mode_lap[c];
        end
        INIT: state_d = RUN;
        RUN: if ((trig_edge && mode_q == MODE_TOGGLE) || long_press) state_d = STOPPED;
        default: state_d = IDLE;
      endcase
    end
    // Outputs: enable trails the state by a cycle so it stays high on the stop cycle's latch
    always_comb begin
      init_d = state_d == INIT;
      enb_d = state_q == INIT || state_q == RUN;
      latch_d = state_q == RUN && (trig_edge || long_press);
    end
    assign bus.latch_count[c] = latch_q;
    assign bus.count_enb[c] = enb_q;
    assign bus.count_init[c] = init_q;
  end
endmodule
